dm_arbiter: RTL and testbench

- Two-port round-robin arbiter and sequencer in front of the single-port data memory of the multi-cycle MIPS CPU.
- Port 0 is the CPU load/store path. Port 1 is the debug/DMA loader.
- Serialises each access into a fixed 3-cycle transaction. Drives the memory's write-enable, word address and write data; registers read data back to the winning requester.

---
 rtl/dm_arb_pkg.sv | 14 +
 rtl/dm_arbiter_if.sv | 56 +++++
 rtl/dm_arbiter_rr_pick2.sv | 20 ++
 rtl/dm_arbiter.sv | 96 +++++++++
 tb/tb_dm_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared constants for the data-memory arbiter.
//   - FSM state codes (2-bit, legacy encoding kept stable for debug dumps)
//   - default word-address / data widths
package dm_arb_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    // Word address matches the memory's addr[8:2]
    localparam int DEF_AW = 7;
    localparam int DEF_DW = 32;

endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: bundle of the two requester ports and the memory port.
//   m0_*  : CPU load/store requester (req/we/addr/wdata in, ack/rdata out)
//   m1_*  : debug/DMA loader requester, same shape as m0
//   mem_* : single-port data memory (we/addr/wdata out, rdata in)
//   busy  : arbiter is mid-transaction
// modport slave  : the arbiter's view
// modport master : the surrounding system's view (requesters + memory)
interface dm_arbiter_if
    import dm_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);

    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );

endinterface

// File: rtl/dm_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin chooser.
//   req0, req1  : pending requests
//   last        : id of the port granted most recently
//   grant_valid : at least one request pending
//   grant_id    : chosen port; on contention the one that did not win last
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) grant_id = ~last;
        else              grant_id = req1;   // single requester (or none: don't care)
    end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port round-robin arbiter/sequencer for the MIPS data memory.
//   clk, rst : system clock (rising edge), async active-high reset
//   bus      : dm_arbiter_if.slave -- m0 (CPU), m1 (debug/DMA), memory port, busy
// Every access is a fixed IDLE -> ACCESS -> RESP sequence. The winner's
// we/addr/wdata are latched on the granting edge so requesters may change
// or drop their inputs afterwards without affecting the transaction.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
)
(
    input  logic         clk,
    input  logic         rst,
    dm_arbiter_if.slave  bus
);

    logic [1:0]          state;
    logic                owner;
    logic                last_grant;
    logic                we_lat;
    logic [AW-1:0]       addr_lat;
    logic [DW-1:0]       wdata_lat;
    logic [DW-1:0]       rdata_reg;

    // Per-port views so the winner can be selected by index
    logic [1:0]          req;
    logic [1:0]          we_in;
    logic [1:0][AW-1:0]  addr_in;
    logic [1:0][DW-1:0]  wdata_in;

    logic                grant_valid;
    logic                grant_id;

    assign req      = {bus.m1_req,   bus.m0_req};
    assign we_in    = {bus.m1_we,    bus.m0_we};
    assign addr_in  = {bus.m1_addr,  bus.m0_addr};
    assign wdata_in = {bus.m1_wdata, bus.m0_wdata};

    rr_pick2 u_pick (
        .req0        (req[0]),
        .req1        (req[1]),
        .last        (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;     // port 0 wins the first contention
            we_lat     <= 1'b0;
            addr_lat   <= '0;
            wdata_lat  <= '0;
            rdata_reg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner     <= grant_id;
                        we_lat    <= we_in[grant_id];
                        addr_lat  <= addr_in[grant_id];
                        wdata_lat <= wdata_in[grant_id];
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Same edge as the memory write commit, so a write
                    // returns the word that was there before it.
                    rdata_reg <= bus.mem_rdata;
                    state     <= RESP;
                end
                RESP: begin
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write enable is decoded from state so an async reset drops it at once
    assign bus.mem_we    = (state == ACCESS) && we_lat;
    assign bus.mem_addr  = addr_lat;
    assign bus.mem_wdata = wdata_lat;

    assign bus.m0_ack    = (state == RESP) && !owner;
    assign bus.m1_ack    = (state == RESP) &&  owner;
    assign bus.m0_rdata  = rdata_reg;
    assign bus.m1_rdata  = rdata_reg;

    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: self-checking bench for dm_arbiter.
// Holds a behavioural data memory, a per-cycle vector table, directed
// multi-cycle sequences and a randomized run against a transaction-level model.
module tb_dm_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dm_arbiter_if #(.AW(AW), .DW(DW)) bus();
    dm_arbiter    #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Data memory: combinational read, write on rising edge
    bit [DW-1:0] mem [128];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            bus.m0_req = r; bus.m0_we = w; bus.m0_addr = a; bus.m0_wdata = d;
        end else begin
            bus.m1_req = r; bus.m1_we = w; bus.m1_addr = a; bus.m1_wdata = d;
        end
    endtask

    function automatic logic ack_of(input int p);
        return (p == 0) ? bus.m0_ack : bus.m1_ack;
    endfunction

    function automatic logic [DW-1:0] rdata_of(input int p);
        return (p == 0) ? bus.m0_rdata : bus.m1_rdata;
    endfunction

    // Full request/ack handshake with a bounded wait; req dropped after ack
    task automatic do_txn(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output logic [DW-1:0] rd);
        bit got;
        got = 0;
        rd  = '0;
        drive(p, 1'b1, w, a, d);
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            if (ack_of(p)) begin
                got = 1;
                rd  = rdata_of(p);
            end
        end
        drive(p, 1'b0, 1'b0, '0, '0);
        chk($sformatf("txn_ack_p%0d", p), 64'(got), 64'd1);
    endtask

    // One cycle of stimulus and the outputs expected after the next edge
    typedef struct {
        logic          r0, w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1, w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          ack0, ack1, we, busy;
        logic [AW-1:0] addr;
        logic [DW-1:0] rdata;
    } vec_t;

    function automatic vec_t mk(logic r0, logic w0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                                logic r1, logic w1, logic [AW-1:0] a1, logic [DW-1:0] d1,
                                logic ack0, logic ack1, logic we, logic busy,
                                logic [AW-1:0] addr, logic [DW-1:0] rdata);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.ack0 = ack0; v.ack1 = ack1; v.we = we; v.busy = busy;
        v.addr = addr; v.rdata = rdata;
        return v;
    endfunction

    vec_t tv [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd;
        int            q_port [$];
        int            q_edge [$];
        logic [DW-1:0] q_data [$];
        bit [DW-1:0]   ref_mem [128];
        bit            pend [2];
        bit            acked [2];
        logic          pw [2];
        logic [AW-1:0] pa [2];
        logic [DW-1:0] pd [2];
        int            free_e, g_edge, e, phase;
        bit            have_g, last;
        int            g_port;
        logic          g_we;
        logic [AW-1:0] g_addr;
        logic [DW-1:0] g_wdata, g_rdata;

        // ---------------- reset ----------------
        rst = 1'b1;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy",  64'(bus.busy),     0);
        chk("rst_we",    64'(bus.mem_we),   0);
        chk("rst_ack0",  64'(bus.m0_ack),   0);
        chk("rst_ack1",  64'(bus.m1_ack),   0);
        chk("rst_addr",  64'(bus.mem_addr), 0);
        chk("rst_rdata", 64'(bus.m0_rdata), 0);

        // ---------------- vector table ----------------
        tv[0]  = mk(1,1,5,32'hDEADBEEF, 0,0,0,0,       0,0,1,1, 5, 0);
        tv[1]  = mk(1,1,5,32'hDEADBEEF, 0,0,0,0,       1,0,0,1, 5, 0);
        tv[2]  = mk(0,0,0,0,            1,0,5,0,       0,0,0,0, 5, 0);
        tv[3]  = mk(0,0,0,0,            1,0,5,0,       0,0,0,1, 5, 0);
        tv[4]  = mk(0,0,0,0,            1,0,5,0,       0,1,0,1, 5, 32'hDEADBEEF);
        tv[5]  = mk(0,0,0,0,            0,0,0,0,       0,0,0,0, 5, 0);
        tv[6]  = mk(1,0,5,0,            1,1,3,32'h11,  0,0,0,1, 5, 0);
        tv[7]  = mk(1,0,5,0,            1,1,3,32'h11,  1,0,0,1, 5, 32'hDEADBEEF);
        tv[8]  = mk(0,0,0,0,            1,1,3,32'h11,  0,0,0,0, 5, 0);
        tv[9]  = mk(0,0,0,0,            1,1,3,32'h11,  0,0,1,1, 3, 0);
        tv[10] = mk(0,0,0,0,            1,1,3,32'h11,  0,1,0,1, 3, 0);
        tv[11] = mk(0,0,0,0,            0,0,0,0,       0,0,0,0, 3, 0);

        for (int i = 0; i < 12; i++) begin
            drive(0, tv[i].r0, tv[i].w0, tv[i].a0, tv[i].d0);
            drive(1, tv[i].r1, tv[i].w1, tv[i].a1, tv[i].d1);
            step();
            chk($sformatf("v%0d_ack0", i), 64'(bus.m0_ack),   64'(tv[i].ack0));
            chk($sformatf("v%0d_ack1", i), 64'(bus.m1_ack),   64'(tv[i].ack1));
            chk($sformatf("v%0d_we",   i), 64'(bus.mem_we),   64'(tv[i].we));
            chk($sformatf("v%0d_busy", i), 64'(bus.busy),     64'(tv[i].busy));
            chk($sformatf("v%0d_addr", i), 64'(bus.mem_addr), 64'(tv[i].addr));
            if (tv[i].ack0 || tv[i].ack1) begin
                chk($sformatf("v%0d_rdata0", i), 64'(bus.m0_rdata), 64'(tv[i].rdata));
                chk($sformatf("v%0d_rdata1", i), 64'(bus.m1_rdata), 64'(tv[i].rdata));
            end
        end

        // ---------------- async reset mid-cycle clears held registers ----------------
        #3 rst = 1'b1;
        #1;
        chk("arst_addr",  64'(bus.mem_addr),  0);
        chk("arst_wdata", 64'(bus.mem_wdata), 0);
        chk("arst_busy",  64'(bus.busy),      0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ---------------- contention from reset: 0,1,0,1 ----------------
        drive(0, 1, 0, 3, 0);
        drive(1, 1, 0, 5, 0);
        for (int k = 1; k <= 11; k++) begin
            step();
            if (bus.m0_ack) begin q_port.push_back(0); q_edge.push_back(k); q_data.push_back(bus.m0_rdata); end
            if (bus.m1_ack) begin q_port.push_back(1); q_edge.push_back(k); q_data.push_back(bus.m1_rdata); end
        end
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        step();
        step();
        chk("cont_idle", 64'(bus.busy), 0);
        chk("cont_nacks", 64'(q_port.size()), 4);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("cont%0d_port", j), 64'((j < q_port.size()) ? q_port[j] : 99), 64'(j % 2));
            chk($sformatf("cont%0d_edge", j), 64'((j < q_edge.size()) ? q_edge[j] : 99), 64'(2 + 3*j));
            chk($sformatf("cont%0d_data", j), 64'((j < q_data.size()) ? q_data[j] : '1),
                64'((j % 2) ? 32'hDEADBEEF : 32'h11));
        end

        // ---------------- write read-back ----------------
        do_txn(1, 1, 3, 32'h22, rd);
        chk("wrb_old", 64'(rd), 64'h11);
        do_txn(0, 0, 3, 32'h0, rd);
        chk("wrb_new", 64'(rd), 64'h22);

        // ---------------- late input changes / req dropped early ----------------
        step();
        chk("late_idle0", 64'(bus.busy), 0);
        drive(0, 1, 1, 10, 32'hAAAA0001);
        step();
        chk("late_we",   64'(bus.mem_we),   1);
        chk("late_addr", 64'(bus.mem_addr), 10);
        drive(0, 0, 1, 11, 32'hBBBB0002);
        #1;
        chk("late_addr_hold",  64'(bus.mem_addr),  10);
        chk("late_wdata_hold", 64'(bus.mem_wdata), 64'hAAAA0001);
        step();
        chk("late_ack", 64'(bus.m0_ack), 1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("late_nobusy%0d", k), 64'(bus.busy), 0);
        end
        chk("late_mem10", 64'(mem[10]), 64'hAAAA0001);
        chk("late_mem11", 64'(mem[11]), 0);

        // ---------------- reset during ACCESS of a write ----------------
        do_txn(1, 1, 9, 32'h99, rd);
        step();
        drive(0, 1, 1, 9, 32'h5555);
        step();
        chk("racc_we_before", 64'(bus.mem_we), 1);
        drive(0, 0, 0, '0, '0);
        #3 rst = 1'b1;
        #1;
        chk("racc_we_drop", 64'(bus.mem_we), 0);
        chk("racc_busy",    64'(bus.busy),   0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("racc_noack%0d", k), 64'({bus.m0_ack, bus.m1_ack}), 0);
        end
        chk("racc_mem9_kept", 64'(mem[9]), 64'h99);
        do_txn(0, 1, 9, 32'h5555, rd);
        chk("racc_retry_rd", 64'(rd), 64'h99);
        chk("racc_mem9_new", 64'(mem[9]), 64'h5555);

        // ---------------- randomized run against a transaction model ----------------
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 128; i++) ref_mem[i] = mem[i];
        pend   = '{0, 0};
        acked  = '{0, 0};
        free_e = 0;
        have_g = 0;
        last   = 1;
        g_edge = 0; g_port = 0; g_we = 0; g_addr = '0; g_wdata = '0; g_rdata = '0;
        for (e = 0; e < 450; e++) begin
            // requesters: hold until ack, then drop or start a new request
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && acked[p]) pend[p] = 0;
                if (!pend[p] && ($urandom_range(0, 2) == 0)) begin
                    pend[p] = 1;
                    pw[p]   = $urandom_range(0, 1);
                    pa[p]   = AW'($urandom_range(0, 15));
                    pd[p]   = $urandom;
                end
                if (pend[p]) drive(p, 1, pw[p], pa[p], pd[p]);
                else         drive(p, 0, 0, '0, '0);
            end
            // model: an idle arbiter grants on this edge; busy for three edges
            if (e >= free_e && (pend[0] || pend[1])) begin
                g_port  = (pend[0] && pend[1]) ? int'(!last) : (pend[1] ? 1 : 0);
                g_we    = pw[g_port];
                g_addr  = pa[g_port];
                g_wdata = pd[g_port];
                g_rdata = ref_mem[g_addr];
                if (g_we) ref_mem[g_addr] = g_wdata;
                g_edge  = e;
                have_g  = 1;
                last    = g_port[0];
                free_e  = e + 3;
            end
            step();
            phase = have_g ? (e - g_edge) : 100;
            chk("rnd_we",   64'(bus.mem_we), 64'(phase == 0 && g_we));
            chk("rnd_busy", 64'(bus.busy),   64'(phase <= 1));
            chk("rnd_ack0", 64'(bus.m0_ack), 64'(phase == 1 && g_port == 0));
            chk("rnd_ack1", 64'(bus.m1_ack), 64'(phase == 1 && g_port == 1));
            if (phase == 0) begin
                chk("rnd_addr", 64'(bus.mem_addr), 64'(g_addr));
                if (g_we) chk("rnd_wdata", 64'(bus.mem_wdata), 64'(g_wdata));
            end
            if (phase == 1) chk("rnd_rdata", 64'(rdata_of(g_port)), 64'(g_rdata));
            acked[0] = bus.m0_ack;
            acked[1] = bus.m1_ack;
        end
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        repeat (4) step();
        for (int i = 0; i < 16; i++)
            chk($sformatf("rnd_mem%0d", i), 64'(mem[i]), 64'(ref_mem[i]));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
